sd_cmd_arbiter: RTL and testbench

SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

---
 rtl/sd_host_pkg.sv | 14 +
 rtl/sd_arb_watchdog.sv | 29 ++
 rtl/sd_cmd_arbiter.sv | 128 ++++++++++++
 tb/tb_sd_cmd_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_host_pkg.sv
// sd_host_pkg: shared owner/state encodings and command-field widths for the SD host path
package sd_host_pkg;
  localparam int CLKDIV_W = 16;
  localparam int PRECNT_W = 16;
  localparam int CMD_W    = 6;
  localparam int ARG_W    = 32;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_RD = 2'd1, OWN_WR = 2'd2} owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_OWN_R, ST_OWN_W, ST_DRAIN} state_e;
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/sd_arb_watchdog.sv
// sd_arb_watchdog: counts in-flight cycles and flags a command the engine never completes
module sd_arb_watchdog #(
  parameter logic [31:0] LIMIT = 32'd4000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);
  logic        run_q;
  logic [31:0] cnt_q;
  // the issuing cycle counts as the first in-flight cycle
  assign expire_o = run_q && (cnt_q >= LIMIT - 32'd1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (expire_o || (clear_i && !start_i)) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= 32'd1;
    end else if (run_q) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: shares one SD command engine between the card reader and writer
module sd_cmd_arbiter
  import sd_host_pkg::*;
#(
  parameter logic [CLKDIV_W-1:0] IDLE_CLKDIV = 16'd4,
  parameter logic [31:0]         WDOG_CYC    = 32'd4000000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                init_done,
  input  logic                r_req,
  input  logic                w_req,
  output logic                r_gnt,
  output logic                w_gnt,
  input  logic [CLKDIV_W-1:0] r_clkdiv,
  input  logic                r_start,
  input  logic [PRECNT_W-1:0] r_precnt,
  input  logic [CMD_W-1:0]    r_cmd,
  input  logic [ARG_W-1:0]    r_arg,
  input  logic [CLKDIV_W-1:0] w_clkdiv,
  input  logic                w_start,
  input  logic [PRECNT_W-1:0] w_precnt,
  input  logic [CMD_W-1:0]    w_cmd,
  input  logic [ARG_W-1:0]    w_arg,
  output logic                r_busy,
  output logic                r_done,
  output logic                r_timeout,
  output logic                r_syntaxe,
  output logic [ARG_W-1:0]    r_resparg,
  output logic                w_busy,
  output logic                w_done,
  output logic                w_timeout,
  output logic                w_syntaxe,
  output logic [ARG_W-1:0]    w_resparg,
  output logic [CLKDIV_W-1:0] h_clkdiv,
  output logic                h_start,
  output logic [PRECNT_W-1:0] h_precnt,
  output logic [CMD_W-1:0]    h_cmd,
  output logic [ARG_W-1:0]    h_arg,
  input  logic                h_busy,
  input  logic                h_done,
  input  logic                h_timeout,
  input  logic                h_syntaxe,
  input  logic [ARG_W-1:0]    h_resparg,
  input  logic                w_dat0_oe,
  input  logic                w_dat0_out,
  output logic                sddat0_oe,
  output logic                sddat0_out,
  output logic [1:0]          owner,
  output logic [7:0]          drop_cnt,
  output logic                wdog_err
);
  state_e              state_q;
  logic                r_gnt_q, w_gnt_q, last_w_q, inflight_q, inflight_d, wdog_q, expire;
  logic [CLKDIV_W-1:0] clkdiv_q;
  logic [7:0]          drop_q;
  logic                w_ok, pick_r;
  assign r_gnt      = r_gnt_q;
  assign w_gnt      = w_gnt_q;
  assign owner      = w_gnt_q ? OWN_WR : r_gnt_q ? OWN_RD : OWN_NONE;
  assign drop_cnt   = drop_q;
  assign wdog_err   = wdog_q;
  assign h_clkdiv   = r_gnt_q ? r_clkdiv : w_gnt_q ? w_clkdiv : clkdiv_q;
  assign h_precnt   = r_gnt_q ? r_precnt : w_gnt_q ? w_precnt : '0;
  assign h_cmd      = r_gnt_q ? r_cmd : w_gnt_q ? w_cmd : '0;
  assign h_arg      = r_gnt_q ? r_arg : w_gnt_q ? w_arg : '0;
  assign h_start    = (r_start & r_gnt_q) | (w_start & w_gnt_q);
  assign r_busy     = r_gnt_q ? h_busy : 1'b1;
  assign w_busy     = w_gnt_q ? h_busy : 1'b1;
  assign r_done     = r_gnt_q & h_done;
  assign w_done     = w_gnt_q & h_done;
  assign r_timeout  = r_gnt_q & h_timeout;
  assign w_timeout  = w_gnt_q & h_timeout;
  assign r_syntaxe  = r_gnt_q & h_syntaxe;
  assign w_syntaxe  = w_gnt_q & h_syntaxe;
  assign r_resparg  = r_gnt_q ? h_resparg : '0;
  assign w_resparg  = w_gnt_q ? h_resparg : '0;
  assign sddat0_oe  = w_dat0_oe & w_gnt_q;
  assign sddat0_out = w_dat0_out;
  // the writer may only compete once the reader has initialised the card
  assign w_ok       = w_req & init_done;
  assign pick_r     = r_req & (!w_ok | last_w_q);
  assign inflight_d = expire ? 1'b0 : h_start ? 1'b1 : h_done ? 1'b0 : inflight_q;
  sd_arb_watchdog #(.LIMIT(WDOG_CYC)) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (h_start),
    .clear_i  (h_done),
    .expire_o (expire)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      r_gnt_q    <= 1'b0;
      w_gnt_q    <= 1'b0;
      last_w_q   <= 1'b1;
      clkdiv_q   <= IDLE_CLKDIV;
      inflight_q <= 1'b0;
      drop_q     <= '0;
      wdog_q     <= 1'b0;
    end else begin
      clkdiv_q   <= h_clkdiv;
      inflight_q <= inflight_d;
      drop_q     <= sat_add8(drop_q, {1'b0, r_start & !r_gnt_q} + {1'b0, w_start & !w_gnt_q});
      if (expire) wdog_q <= 1'b1;
      case (state_q)
        ST_IDLE:
          if (pick_r) begin
            state_q  <= ST_OWN_R;
            r_gnt_q  <= 1'b1;
            last_w_q <= 1'b0;
          end else if (w_ok) begin
            state_q  <= ST_OWN_W;
            w_gnt_q  <= 1'b1;
            last_w_q <= 1'b1;
          end
        ST_OWN_R, ST_OWN_W:
          if (expire || !(r_gnt_q ? r_req : w_req)) begin
            state_q <= inflight_d ? ST_DRAIN : ST_IDLE;
            r_gnt_q <= 1'b0;
            w_gnt_q <= 1'b0;
          end
        default:
          if (expire || h_done) state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb_sd_cmd_arbiter: directed stimulus with a scoreboard monitor for grants, commands and responses
module tb_sd_cmd_arbiter;
  logic        clk = 1'b0, rstn = 1'b1;
  logic        init_done, r_req, w_req, r_gnt, w_gnt;
  logic [15:0] r_clkdiv, w_clkdiv, r_precnt, w_precnt, h_clkdiv, h_precnt;
  logic        r_start, w_start, h_start;
  logic [5:0]  r_cmd, w_cmd, h_cmd;
  logic [31:0] r_arg, w_arg, h_arg, r_resparg, w_resparg, h_resparg;
  logic        r_busy, r_done, r_timeout, r_syntaxe;
  logic        w_busy, w_done, w_timeout, w_syntaxe;
  logic        h_busy, h_done, h_timeout, h_syntaxe;
  logic        w_dat0_oe, w_dat0_out, sddat0_oe, sddat0_out, wdog_err;
  logic [1:0]  owner, last_own = 2'd0;
  logic [7:0]  drop_cnt;
  logic [1:0]  q_own[$];
  logic [69:0] q_cmd[$];
  logic [67:0] q_done[$];
  int          errors = 0, checks = 0;

  sd_cmd_arbiter #(.IDLE_CLKDIV(16'd4), .WDOG_CYC(32'd100)) dut (
    .clk(clk), .rstn(rstn), .init_done(init_done), .r_req(r_req), .w_req(w_req),
    .r_gnt(r_gnt), .w_gnt(w_gnt),
    .r_clkdiv(r_clkdiv), .r_start(r_start), .r_precnt(r_precnt), .r_cmd(r_cmd), .r_arg(r_arg),
    .w_clkdiv(w_clkdiv), .w_start(w_start), .w_precnt(w_precnt), .w_cmd(w_cmd), .w_arg(w_arg),
    .r_busy(r_busy), .r_done(r_done), .r_timeout(r_timeout), .r_syntaxe(r_syntaxe), .r_resparg(r_resparg),
    .w_busy(w_busy), .w_done(w_done), .w_timeout(w_timeout), .w_syntaxe(w_syntaxe), .w_resparg(w_resparg),
    .h_clkdiv(h_clkdiv), .h_start(h_start), .h_precnt(h_precnt), .h_cmd(h_cmd), .h_arg(h_arg),
    .h_busy(h_busy), .h_done(h_done), .h_timeout(h_timeout), .h_syntaxe(h_syntaxe), .h_resparg(h_resparg),
    .w_dat0_oe(w_dat0_oe), .w_dat0_out(w_dat0_out), .sddat0_oe(sddat0_oe), .sddat0_out(sddat0_out),
    .owner(owner), .drop_cnt(drop_cnt), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [69:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every owner change, issued command and forwarded completion must match the scoreboard
  always @(negedge clk) begin
    if (owner !== last_own) begin
      if (q_own.size() == 0) unexpected("owner_change", owner);
      else check("owner_seq", owner, q_own.pop_front());
      last_own = owner;
    end
    if (h_start) begin
      if (q_cmd.size() == 0) unexpected("h_start", {h_cmd, h_arg, h_clkdiv, h_precnt});
      else check("h_cmd_fields", {h_cmd, h_arg, h_clkdiv, h_precnt}, q_cmd.pop_front());
    end
    if (r_done || w_done) begin
      if (q_done.size() == 0) unexpected("done_fwd", {r_done, w_done, r_syntaxe, w_syntaxe, r_resparg, w_resparg});
      else check("done_fwd", {r_done, w_done, r_syntaxe, w_syntaxe, r_resparg, w_resparg}, q_done.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    {init_done, r_req, w_req, r_start, w_start, h_busy, h_done, h_timeout, h_syntaxe, w_dat0_out} = '0;
    {r_clkdiv, w_clkdiv, r_precnt, w_precnt, r_cmd, w_cmd, r_arg, w_arg, h_resparg} = '0;
    w_dat0_oe = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst_r_gnt", r_gnt, 0);
    check("rst_w_gnt", w_gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_h_clkdiv", h_clkdiv, 16'd4);
    check("rst_sddat0_oe", sddat0_oe, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_wdog_err", wdog_err, 0);
    check("rst_r_busy", r_busy, 1);
    tick(2);
    rstn = 1'b1;
    tick(1);
    // reader only before init_done
    r_req = 1; w_req = 1; q_own.push_back(2'd1);
    tick(1);
    check("r_gnt_cycle1", r_gnt, 1);
    check("owner_reader", owner, 2'd1);
    check("w_gnt_pre_init", w_gnt, 0);
    r_clkdiv = 16'd8; r_precnt = 16'd3; r_cmd = 6'd17; r_arg = 32'h200; r_start = 1; w_start = 1;
    q_cmd.push_back({6'd17, 32'h200, 16'd8, 16'd3});
    #1;
    check("r_busy_granted", r_busy, 0);
    check("w_busy_idle", w_busy, 1);
    check("sddat0_oe_not_gnt", sddat0_oe, 0);
    tick(1);
    r_start = 0; w_start = 0;
    h_done = 1; h_syntaxe = 1; h_resparg = 32'hABCD;
    q_done.push_back({1'b1, 1'b0, 1'b1, 1'b0, 32'hABCD, 32'h0});
    #1;
    check("drop_one", drop_cnt, 8'd1);
    check("h_clkdiv_reader", h_clkdiv, 16'd8);
    tick(1);
    h_done = 0; h_syntaxe = 0; h_resparg = 0;
    r_req = 0; q_own.push_back(2'd0);
    tick(2);
    check("w_pend_no_init", w_gnt, 0);
    check("h_clkdiv_held", h_clkdiv, 16'd8);
    rstn = 1'b0; w_req = 0;
    #1;
    check("rst2_drop_cnt", drop_cnt, 0);
    check("rst2_h_clkdiv", h_clkdiv, 16'd4);
    tick(1);
    rstn = 1'b1;
    // round-robin after reset: reader first, then writer
    init_done = 1;
    tick(1);
    r_req = 1; w_req = 1; q_own.push_back(2'd1);
    tick(1);
    check("rr_reader_first", r_gnt, 1);
    check("rr_writer_wait", w_gnt, 0);
    r_req = 0; q_own.push_back(2'd0); q_own.push_back(2'd2);
    tick(1);
    check("rr_idle_gap", {r_gnt, w_gnt}, 2'b00);
    tick(1);
    check("rr_writer_gnt", w_gnt, 1);
    check("owner_writer", owner, 2'd2);
    r_req = 1; w_dat0_out = 1;
    #1;
    check("sddat0_oe_writer", sddat0_oe, 1);
    check("sddat0_out_writer", sddat0_out, 1);
    w_clkdiv = 16'd2; w_cmd = 6'd24; w_arg = 32'h1000; w_precnt = 16'h10; w_start = 1; r_start = 1;
    q_cmd.push_back({6'd24, 32'h1000, 16'd2, 16'h10});
    #1;
    check("h_cmd_24", h_cmd, 6'd24);
    check("h_arg_1000", h_arg, 32'h1000);
    tick(1);
    w_start = 0; r_start = 0;
    h_done = 1; h_resparg = 32'h55;
    q_done.push_back({1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h55});
    #1;
    check("drop_one_again", drop_cnt, 8'd1);
    check("writer_keeps", w_gnt, 1);
    tick(1);
    h_done = 0; h_resparg = 0;
    for (int i = 0; i < 299; i++) begin
      r_start = 1;
      tick(1);
      r_start = 0;
      tick(1);
    end
    check("drop_saturate", drop_cnt, 8'd255);
    // writer releases while a command is in flight
    w_cmd = 6'd25; w_arg = 32'h2000; w_start = 1;
    q_cmd.push_back({6'd25, 32'h2000, 16'd2, 16'h10});
    tick(1);
    w_start = 0; w_req = 0; q_own.push_back(2'd0);
    tick(1);
    check("drain_gnt_low", w_gnt, 0);
    tick(2);
    check("drain_r_wait", r_gnt, 0);
    w_req = 1; h_done = 1; h_resparg = 32'h77; q_own.push_back(2'd1);
    #1;
    check("drain_r_done", r_done, 0);
    check("drain_w_done", w_done, 0);
    tick(1);
    h_done = 0; h_resparg = 0;
    check("drain_idle_gap", r_gnt, 0);
    tick(1);
    check("rr_reader_after_w", {r_gnt, w_gnt}, 2'b10);
    // watchdog: command never completes
    r_clkdiv = 16'd6; r_cmd = 6'd55; r_arg = 32'hDEAD; r_start = 1;
    q_cmd.push_back({6'd55, 32'hDEAD, 16'd6, 16'd3});
    tick(1);
    r_start = 0;
    tick(98);
    check("wdog_pre", wdog_err, 0);
    check("wdog_pre_gnt", r_gnt, 1);
    q_own.push_back(2'd0);
    tick(1);
    check("wdog_err", wdog_err, 1);
    check("wdog_gnt", r_gnt, 0);
    check("wdog_owner", owner, 0);
    r_req = 0; w_req = 0;
    tick(1);
    // reset while the writer owns the bus and drives DAT0
    w_req = 1; w_clkdiv = 16'd12; q_own.push_back(2'd2);
    tick(1);
    check("w_gnt_again", w_gnt, 1);
    check("h_clkdiv_writer", h_clkdiv, 16'd12);
    check("sddat0_oe_own_w", sddat0_oe, 1);
    w_cmd = 6'd18; w_arg = 32'h3000; w_start = 1;
    q_cmd.push_back({6'd18, 32'h3000, 16'd12, 16'h10});
    tick(1);
    w_start = 0; q_own.push_back(2'd0);
    #2 rstn = 1'b0;
    w_req = 0; h_done = 1;
    #1;
    check("midrst_sddat0_oe", sddat0_oe, 0);
    check("midrst_h_clkdiv", h_clkdiv, 16'd4);
    check("midrst_w_gnt", w_gnt, 0);
    tick(1);
    rstn = 1'b1;
    #1;
    check("post_rst_w_done", w_done, 0);
    check("post_rst_wdog", wdog_err, 0);
    check("post_rst_drop", drop_cnt, 0);
    tick(1);
    h_done = 0;
    tick(3);
    check("q_own_empty", q_own.size(), 0);
    check("q_cmd_empty", q_cmd.size(), 0);
    check("q_done_empty", q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
